// File: rtl/host_sequencer.sv
// host_sequencer
//   Sequences one job through four phases:
//   - load host words into shared memory
//   - launch the cores and wait until every core reports done
//   - stream the result words back to the host
//   - return to idle
//
// Build option:
//   SEQ_TIMEOUT_EN  When defined, a RUN watchdog down-counter is built. When
//                   it reaches terminal count, it sets the sticky timeout and
//                   forces the move to UNLOAD. When undefined there is no
//                   counter, and RUN waits for the cores indefinitely.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   load_start           host request to load (IDLE only)
//   in_data, in_valid    host load word and its qualifier (LOAD only)
//   load_done            end of load (LOAD only)
//   mem_addr/wdata/wr_en shared-memory write/read port (registered)
//   mem_rdata            shared-memory read data, one cycle after mem_addr
//   core_start           one-cycle launch pulse on the first RUN cycle
//   core_done            per-core completion, pulse or level
//   out_data/valid/ready result stream to host (valid/ready handshake)
//   unload_start         high throughout UNLOAD
//   unload_done          one-cycle pulse after the last word is accepted
//   state                IDLE=11, LOAD=00, RUN=01, UNLOAD=10
//   load_overflow        sticky: load write pointer wrapped
//   timeout              sticky: RUN watchdog expired
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | waiting for load_start
// LOAD   | writing host words to memory at an incrementing pointer
// RUN    | cores launched; collecting core_done into the done mask
// UNLOAD | FETCH (out_valid=0) / PRESENT (out_valid=1) per result word

module host_sequencer #(
  parameter int DATA_W         = 16,
  parameter int ADDR_W         = 16,
  parameter int NUM_CORES      = 4,
  parameter int OUT_WORDS      = 1025,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load_start,
  input  logic [DATA_W-1:0]    in_data,
  input  logic                 in_valid,
  input  logic                 load_done,
  output logic [ADDR_W-1:0]    mem_addr,
  output logic [DATA_W-1:0]    mem_wdata,
  output logic                 mem_wr_en,
  input  logic [DATA_W-1:0]    mem_rdata,
  output logic                 core_start,
  input  logic [NUM_CORES-1:0] core_done,
  output logic [DATA_W-1:0]    out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 unload_start,
  output logic                 unload_done,
  output logic [1:0]           state,
  output logic                 load_overflow,
  output logic                 timeout
);

  typedef enum logic [1:0] {
    ST_LOAD   = 2'b00,
    ST_RUN    = 2'b01,
    ST_UNLOAD = 2'b10,
    ST_IDLE   = 2'b11
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_RD = ADDR_W'(OUT_WORDS - 1);

  state_e                state_q, state_d;
  logic [ADDR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [NUM_CORES-1:0]  mask_q, mask_d, mask_nxt;
  logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
  logic                  mem_wr_en_q, mem_wr_en_d;
  logic                  core_start_q, core_start_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_cap_q, out_cap_d;
  logic [DATA_W-1:0]     out_data_q, out_data_d;
  logic                  unload_done_q, unload_done_d;
  logic                  ovf_q, ovf_d;
  logic                  timeout_q, timeout_d;
  logic                  tmr_tc;

`ifdef SEQ_TIMEOUT_EN
  localparam int TMR_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT_CYCLES - 1);

  logic [TMR_W-1:0] run_tmr_q, run_tmr_d;
  logic             run_entry;

  assign run_entry = (state_q == ST_LOAD) && load_done;
  assign tmr_tc    = (run_tmr_q == '0);

  // Loaded on the way into RUN, so terminal count lands on the last
  // allowed RUN cycle.
  always_comb begin
    run_tmr_d = run_tmr_q;
    if (run_entry) begin
      run_tmr_d = TMR_LOAD;
    end else if ((state_q == ST_RUN) && !tmr_tc) begin
      run_tmr_d = run_tmr_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_tmr_q <= '0;
    end else begin
      run_tmr_q <= run_tmr_d;
    end
  end
`else
  assign tmr_tc = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    mask_d        = mask_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_wr_en_d   = 1'b0;
    core_start_d  = 1'b0;
    out_valid_d   = out_valid_q;
    out_cap_d     = 1'b0;
    out_data_d    = out_data_q;
    unload_done_d = 1'b0;
    ovf_d         = ovf_q;
    timeout_d     = timeout_q;
    mask_nxt      = mask_q | core_done;

    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          wr_ptr_d  = '0;
          ovf_d     = 1'b0;
          timeout_d = 1'b0;
          state_d   = ST_LOAD;
        end
      end

      ST_LOAD: begin
        // Once the pointer has wrapped, further words are dropped so
        // nothing already loaded gets overwritten.
        if (in_valid && !ovf_q) begin
          mem_wr_en_d = 1'b1;
          mem_addr_d  = wr_ptr_q;
          mem_wdata_d = in_data;
          wr_ptr_d    = wr_ptr_q + 1'b1;
          if (&wr_ptr_q) begin
            ovf_d = 1'b1;
          end
        end
        if (load_done) begin
          state_d      = ST_RUN;
          core_start_d = 1'b1;
          mask_d       = '0;
        end
      end

      ST_RUN: begin
        mask_d = mask_nxt;
        if (&mask_nxt || tmr_tc) begin
          state_d     = ST_UNLOAD;
          rd_ptr_d    = '0;
          mem_addr_d  = '0;
          out_valid_d = 1'b0;
          if (!(&mask_nxt)) begin
            timeout_d = 1'b1;
          end
        end
      end

      ST_UNLOAD: begin
        if (!out_valid_q) begin
          // FETCH: mem_addr already holds rd_ptr; data arrives next cycle.
          out_valid_d = 1'b1;
          out_cap_d   = 1'b1;
        end else begin
          if (out_cap_q) begin
            out_data_d = mem_rdata;
          end
          if (out_ready) begin
            out_valid_d = 1'b0;
            if (rd_ptr_q == LAST_RD) begin
              unload_done_d = 1'b1;
              state_d       = ST_IDLE;
            end else begin
              rd_ptr_d   = rd_ptr_q + 1'b1;
              mem_addr_d = rd_ptr_q + 1'b1;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      mask_q        <= '0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_wr_en_q   <= 1'b0;
      core_start_q  <= 1'b0;
      out_valid_q   <= 1'b0;
      out_cap_q     <= 1'b0;
      out_data_q    <= '0;
      unload_done_q <= 1'b0;
      ovf_q         <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      mask_q        <= mask_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_wr_en_q   <= mem_wr_en_d;
      core_start_q  <= core_start_d;
      out_valid_q   <= out_valid_d;
      out_cap_q     <= out_cap_d;
      out_data_q    <= out_data_d;
      unload_done_q <= unload_done_d;
      ovf_q         <= ovf_d;
      timeout_q     <= timeout_d;
    end
  end

  // The memory returns data in the first PRESENT cycle, so that cycle
  // passes mem_rdata straight through. The captured copy then holds the
  // word steady while the host stalls.
  assign out_data      = out_cap_q ? mem_rdata : out_data_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wr_en     = mem_wr_en_q;
  assign core_start    = core_start_q;
  assign out_valid     = out_valid_q;
  assign unload_start  = (state_q == ST_UNLOAD);
  assign unload_done   = unload_done_q;
  assign state         = state_q;
  assign load_overflow = ovf_q;
  assign timeout       = timeout_q;

endmodule

// File: doc/host_sequencer.md
HOST_SEQUENCER -- requirements
Module: host_sequencer

Interface
REQ-001 Parameter DATA_W, default 16, word width of host and memory data.
REQ-002 Parameter ADDR_W, default 16, shared-memory address width.
REQ-003 Parameter NUM_CORES, default 4, number of processing cores joined in RUN.
REQ-004 Parameter OUT_WORDS, default 1025, words returned in UNLOAD (addresses 0..OUT_WORDS-1), range 1..2^ADDR_W.
REQ-005 Parameter TIMEOUT_CYCLES, default 1000000, RUN watchdog limit (used only with SEQ_TIMEOUT_EN).
REQ-006 clk  in  1  single clock, all state updates on rising edge.
REQ-007 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-008 load_start  in  1  host request to begin loading; sampled in IDLE only.
REQ-009 in_data  in  DATA_W  host load word.
REQ-010 in_valid  in  1  in_data valid this cycle; sampled in LOAD only.
REQ-011 load_done  in  1  host marks end of load; sampled in LOAD only.
REQ-012 mem_addr  out  ADDR_W  shared-memory address.
REQ-013 mem_wdata  out  DATA_W  shared-memory write data.
REQ-014 mem_wr_en  out  1  shared-memory write strobe.
REQ-015 mem_rdata  in  DATA_W  shared-memory read data, valid one cycle after mem_addr.
REQ-016 core_start  out  1  one-cycle pulse launching all cores.
REQ-017 core_done  in  NUM_CORES  per-core completion, pulse or level.
REQ-018 out_data  out  DATA_W  result word to host.
REQ-019 out_valid  out  1  out_data valid; held until accepted.
REQ-020 out_ready  in  1  host accepts out_data when out_valid and out_ready are both high.
REQ-021 unload_start  out  1  high for the whole UNLOAD state.
REQ-022 unload_done  out  1  one-cycle pulse after the last word is accepted.
REQ-023 state  out  2  IDLE=2'b11, LOAD=2'b00, RUN=2'b01, UNLOAD=2'b10.
REQ-024 load_overflow  out  1  sticky; LOAD write pointer wrapped.
REQ-025 timeout  out  1  sticky; RUN watchdog expired.

Function
REQ-026 IDLE: on load_start, the block shall clear the write pointer to 0, clear load_overflow and timeout, and enter LOAD next cycle.
REQ-027 LOAD: each cycle with in_valid high, the block shall register mem_wr_en=1, mem_wdata=in_data, and mem_addr=pointer for exactly one cycle, then increment the pointer.
REQ-028 LOAD: in_valid low shall give mem_wr_en=0 next cycle, with no pointer change.
REQ-029 Pointer increment from 2^ADDR_W-1 shall set load_overflow; subsequent in_valid words shall be dropped (mem_wr_en=0) until LOAD exits.
REQ-030 load_done high shall move LOAD to RUN next cycle; if in_valid is high in the same cycle, that word shall still be written.
REQ-031 RUN entry: the block shall pulse core_start for the first RUN cycle and clear the done mask.
REQ-032 RUN: each core_done bit shall be captured sticky into the mask; when the mask is all ones (including the current cycle's inputs), the block shall enter UNLOAD next cycle.
REQ-033 UNLOAD: the read pointer shall start at 0; FETCH drives mem_addr=pointer for one cycle, and the next cycle out_data=mem_rdata and out_valid=1.
REQ-034 out_data shall hold stable while out_valid=1 and out_ready=0.
REQ-035 On acceptance, if pointer=OUT_WORDS-1: out_valid=0, unload_done pulses, and the state returns to IDLE; otherwise out_valid=0, pointer+1, and FETCH; maximum rate is one word per 2 cycles.
REQ-036 load_start outside IDLE shall be ignored; core_done outside RUN shall be ignored.
REQ-037 mem_wr_en shall be 0 in all states except LOAD.

Reset
REQ-038 With rst_n low, the block shall hold state=IDLE (2'b11), all pointers and the done mask at 0, and mem_addr, mem_wdata, out_data at 0.
REQ-039 With rst_n low, mem_wr_en, core_start, out_valid, unload_start, unload_done, load_overflow, and timeout shall all be 0.
REQ-040 Reset mid-operation shall abort immediately with no further memory writes, and restart from IDLE on the first edge after release.

Configuration
REQ-041 With SEQ_TIMEOUT_EN defined, a RUN cycle counter shall run; after TIMEOUT_CYCLES cycles in RUN without a full mask, the block shall set timeout and enter UNLOAD.
REQ-042 Without SEQ_TIMEOUT_EN, no counter shall exist, timeout shall be tied to 0, and RUN shall wait indefinitely.

Verification
REQ-043 Load of 8 words with in_valid continuous, then load_done -> addresses 0..7 written with matching data, state 00 -> 01.
REQ-044 in_valid gapped 1-of-3 plus load_done coincident with the last word -> that word is written, with no duplicate writes.
REQ-045 core_done bits pulsed on different cycles (3,0,2,1) -> UNLOAD entered the cycle after bit 1; one core_start pulse only.
REQ-046 UNLOAD with OUT_WORDS=4 and out_ready low for 5 cycles on word 2 -> out_data stable, 4 words in order, unload_done one cycle, state 11.
REQ-047 ADDR_W=3 with 10 valid words -> load_overflow=1, only addresses 0..7 written.
REQ-048 SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=20, one core never done -> timeout=1 after 20 RUN cycles, UNLOAD proceeds; rst_n pulse mid-UNLOAD -> all outputs at reset values.
